calc_ctrl: RTL and testbench

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_calc_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl.sv
// ============================================================================
//  Module   : calc_ctrl
//  Brief    : Two-operand BCD key calculator controller with double-dabble output.
//             Define CALC_NEG_EN to show |A-B| with neg = 1 when A < B on subtract.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] char,
    input  logic       flag,
    output logic [3:0] dig3,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic       neg,
    output logic [1:0] state,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_OPA    = 2'd0,
        ST_OPB    = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [3:0] LAST_STEP = 4'd14;

    state_t      state_q, state_d;
    logic        flag_q;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    logic [15:0] dig_q, dig_d;
    logic        neg_q, neg_d;
    logic        busy_q, busy_d;

    logic        w_evt, w_is_digit, w_is_op, w_is_enter;
    logic [3:0]  w_op_full;
    logic [6:0]  w_a_bin, w_b_bin;
    logic [13:0] w_result;
    logic        w_sign;
    logic [15:0] w_adj, w_bcd_step;
    logic [13:0] w_bin_step;

    function automatic logic [15:0] add3(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        w_evt      = flag ^ flag_q;
        w_is_digit = (char <= 4'd9);
        w_is_op    = (char >= 4'd10) && (char <= 4'd12);
        w_is_enter = (char == 4'd13);
        w_op_full  = char - 4'd10;
    end

    // Operands are kept in BCD; convert to binary only for the compute cycle.
    always_comb begin
        w_a_bin  = {3'd0, a_q[7:4]} * 7'd10 + {3'd0, a_q[3:0]};
        w_b_bin  = {3'd0, b_q[7:4]} * 7'd10 + {3'd0, b_q[3:0]};
        w_result = {7'd0, w_a_bin} + {7'd0, w_b_bin};
        w_sign   = 1'b0;
        if (op_q == OP_SUB) begin
            if (w_a_bin >= w_b_bin) begin
                w_result = {7'd0, w_a_bin} - {7'd0, w_b_bin};
            end else begin
`ifdef CALC_NEG_EN
                w_result = {7'd0, w_b_bin} - {7'd0, w_a_bin};
                w_sign   = 1'b1;
`else
                w_result = 14'd0;
`endif
            end
        end else if (op_q != OP_ADD) begin
            w_result = {7'd0, w_a_bin} * {7'd0, w_b_bin};
        end
    end

    always_comb begin
        w_adj      = add3(bcd_q);
        w_bcd_step = {w_adj[14:0], bin_q[13]};
        w_bin_step = {bin_q[12:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        dig_d   = dig_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        case (state_q)
            ST_OPA: begin
                if (w_evt && w_is_digit) begin
                    a_d   = {a_q[3:0], char};
                    dig_d = {8'h00, a_q[3:0], char};
                end else if (w_evt && w_is_op) begin
                    op_d    = w_op_full[1:0];
                    b_d     = 8'h00;
                    dig_d   = 16'h0000;
                    state_d = ST_OPB;
                end
            end
            ST_OPB: begin
                if (w_evt && w_is_digit) begin
                    b_d   = {b_q[3:0], char};
                    dig_d = {8'h00, b_q[3:0], char};
                end else if (w_evt && w_is_op) begin
                    op_d = w_op_full[1:0];
                end else if (w_evt && w_is_enter) begin
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Step 0 computes the binary result; steps 1..14 shift it into BCD.
                if (cnt_q == 4'd0) begin
                    bin_d  = w_result;
                    bcd_d  = 16'h0000;
                    sign_d = w_sign;
                    cnt_d  = 4'd1;
                end else begin
                    bin_d = w_bin_step;
                    bcd_d = w_bcd_step;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_STEP) begin
                        dig_d   = w_bcd_step;
                        neg_d   = sign_q;
                        busy_d  = 1'b0;
                        state_d = ST_RESULT;
                    end
                end
            end
            default: begin
                if (w_evt && w_is_digit) begin
                    a_d     = {4'h0, char};
                    b_d     = 8'h00;
                    neg_d   = 1'b0;
                    dig_d   = {12'h000, char};
                    state_d = ST_OPA;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OPA;
            flag_q  <= 1'b0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            op_q    <= OP_ADD;
            bin_q   <= 14'd0;
            bcd_q   <= 16'h0000;
            cnt_q   <= 4'd0;
            sign_q  <= 1'b0;
            dig_q   <= 16'h0000;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            dig_q   <= dig_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
        end
    end

    assign dig3  = dig_q[15:12];
    assign dig2  = dig_q[11:8];
    assign dig1  = dig_q[7:4];
    assign dig0  = dig_q[3:0];
    assign neg   = neg_q;
    assign state = state_q;
    assign busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_ctrl.sv
// ============================================================================
//  Module   : tb_calc_ctrl
//  Brief    : Self-checking bench for calc_ctrl: key-sequence table plus corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_calc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] char = 4'd0;
    logic       flag = 1'b0;
    logic [3:0] dig3, dig2, dig1, dig0;
    logic       neg;
    logic [1:0] state;
    logic       busy;

    calc_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .char  (char),
        .flag  (flag),
        .dig3  (dig3),
        .dig2  (dig2),
        .dig1  (dig1),
        .dig0  (dig0),
        .neg   (neg),
        .state (state),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] keys;
        int          nkeys;
        logic [15:0] exp_dig;
        logic        exp_neg;
    } vec_t;

    vec_t        vecs[9];
    logic [16:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          busy_cnt = 0;
    logic        busy_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        char = k;
        flag = ~flag;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("result_timeout", exp_q.size(), 0);
    endtask

    // Scoreboard: compare on each fall of busy that lands in RESULT.
    always @(negedge clk) begin
        logic [16:0] e;
        if (busy) begin
            busy_cnt++;
        end else if (busy_prev) begin
            if (state == 2'd3) begin
                chk("result_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("digits", {dig3, dig2, dig1, dig0}, e[15:0]);
                    chk("neg", neg, e[16]);
                    chk("busy_len", busy_cnt, 15);
                end
            end
            busy_cnt = 0;
        end
        busy_prev = busy;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ks;
        logic [3:0]  key;

        vecs[0] = '{32'h12A34D00, 6, 16'h0046, 1'b0};
        vecs[1] = '{32'h99C99D00, 6, 16'h9801, 1'b0};
`ifdef CALC_NEG_EN
        vecs[2] = '{32'h3B7D0000, 4, 16'h0004, 1'b1};
`else
        vecs[2] = '{32'h3B7D0000, 4, 16'h0000, 1'b0};
`endif
        vecs[3] = '{32'h50B25D00, 6, 16'h0025, 1'b0};
        vecs[4] = '{32'h99A99D00, 6, 16'h0198, 1'b0};
        vecs[5] = '{32'h0C7D0000, 4, 16'h0000, 1'b0};
        vecs[6] = '{32'h42B42D00, 6, 16'h0000, 1'b0};
        vecs[7] = '{32'h1D2AE3D0, 7, 16'h0015, 1'b0};
        vecs[8] = '{32'h7C8D0000, 4, 16'h0056, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_digits", {dig3, dig2, dig1, dig0}, 16'h0000);
        chk("reset_neg", neg, 0);
        chk("reset_state", state, 0);
        chk("reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Oldest digit drops; repeated operator replaces op.
        press(4'd1); press(4'd2); press(4'd3);
        chk("opa_display", {dig3, dig2, dig1, dig0}, 16'h0023);
        chk("opa_state", state, 0);
        press(4'd10);
        chk("opb_state", state, 1);
        chk("opb_display", {dig3, dig2, dig1, dig0}, 16'h0000);
        press(4'd12); press(4'd5);
        chk("opb_display5", {dig3, dig2, dig1, dig0}, 16'h0005);
        exp_q.push_back({1'b0, 16'h0115});
        press(4'd13);
        wait_drain();

        for (int v = 0; v < 9; v++) begin
            ks = vecs[v].keys;
            for (int k = 0; k < vecs[v].nkeys; k++) begin
                key = ks[31 - 4*k -: 4];
                if (k == vecs[v].nkeys - 1) exp_q.push_back({vecs[v].exp_neg, vecs[v].exp_dig});
                press(key);
            end
            wait_drain();
            chk("vec_state_result", state, 3);
        end

        // Key toggled three cycles after enter is dropped.
        press(4'd1); press(4'd2); press(4'd10); press(4'd3); press(4'd4);
        exp_q.push_back({1'b0, 16'h0046});
        char = 4'd13; flag = ~flag;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        char = 4'd8; flag = ~flag;
        @(posedge clk); #1;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("busy_key_dropped_dig", {dig3, dig2, dig1, dig0}, 16'h0046);
        chk("busy_key_dropped_state", state, 3);
        press(4'd7);
        chk("result_digit_state", state, 0);
        chk("result_digit_display", {dig3, dig2, dig1, dig0}, 16'h0007);
        chk("result_digit_neg", neg, 0);

        // Toggle sampled on the BUSY exit edge is dropped.
        press(4'd10); press(4'd1);
        exp_q.push_back({1'b0, 16'h0008});
        char = 4'd13; flag = ~flag;
        @(posedge clk);
        repeat (14) @(posedge clk);
        #1;
        char = 4'd6; flag = ~flag;
        @(posedge clk); #1;
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        chk("exit_edge_state", state, 3);
        chk("exit_edge_digits", {dig3, dig2, dig1, dig0}, 16'h0008);

        // Reset in the 8th BUSY cycle aborts immediately.
        press(4'd9); press(4'd9); press(4'd12); press(4'd9); press(4'd9);
        char = 4'd13; flag = ~flag;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #2;
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        flag = 1'b0;
        #1;
        chk("abort_digits", {dig3, dig2, dig1, dig0}, 16'h0000);
        chk("abort_state", state, 0);
        chk("abort_busy", busy, 0);
        chk("abort_neg", neg, 0);
        @(negedge clk);
        rst_n = 1'b1;
        press(4'd5);
        chk("post_reset_display", {dig3, dig2, dig1, dig0}, 16'h0005);
        chk("post_reset_state", state, 0);

        repeat (20) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
